// File: rtl/alu_display_if.sv
// Capture bus from the sign-magnitude add/sub unit into the display driver.
// The upstream stage (master) drives a one-cycle load strobe with the result and its flags.
interface alu_display_if;
    logic       load;
    logic [3:0] R;
    logic       ZF;
    logic       SF;
    logic       DZF;

    modport master (output load, R, ZF, SF, DZF);
    modport slave  (input  load, R, ZF, SF, DZF);
endinterface

// File: rtl/alu_display_driver.sv
// Holds the last sign-magnitude result and drives a 4-digit multiplexed common-anode display.
// It shows "Err" on divide-by-zero and exposes the held flags on registered LEDs.
module alu_display_driver #(
    parameter int REFRESH_DIV = 50000
) (
    input  logic              clk,
    input  logic              rst,
    alu_display_if.slave      bus,
    output logic [6:0]        seg,
    output logic [3:0]        an,
    output logic [2:0]        flags,
    output logic              valid
);
    localparam int              CW       = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(REFRESH_DIV - 1);

    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_R     = 7'b0101111;

    logic [CW-1:0] cnt;
    logic [1:0]    idx;
    logic [3:0]    r_q;
    logic          zf_q;
    logic          sf_q;
    logic          dzf_q;
    logic [6:0]    seg_next;

    function automatic logic [6:0] digit_code(input logic [2:0] mag);
        case (mag)
            3'd0:    digit_code = 7'b1000000;
            3'd1:    digit_code = 7'b1111001;
            3'd2:    digit_code = 7'b0100100;
            3'd3:    digit_code = 7'b0110000;
            3'd4:    digit_code = 7'b0011001;
            3'd5:    digit_code = 7'b0010010;
            3'd6:    digit_code = 7'b0000010;
            default: digit_code = 7'b1111000;
        endcase
    endfunction

    // NOTE: seg_next gets a default before any branch so no path leaves it unassigned (no latch).
    always_comb begin
        seg_next = SEG_BLANK;
        if (!valid) begin
            seg_next = SEG_DASH;
        end else if (dzf_q) begin
            case (idx)
                2'd2:       seg_next = SEG_E;
                2'd1, 2'd0: seg_next = SEG_R;
                default:    seg_next = SEG_BLANK;
            endcase
        end else begin
            case (idx)
                2'd0:    seg_next = digit_code(r_q[2:0]);
                // Negative zero is shown without a sign.
                2'd1:    seg_next = (r_q[3] && (r_q[2:0] != 3'd0)) ? SEG_DASH : SEG_BLANK;
                default: seg_next = SEG_BLANK;
            endcase
        end
    end

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            idx   <= 2'd0;
            r_q   <= 4'd0;
            zf_q  <= 1'b0;
            sf_q  <= 1'b0;
            dzf_q <= 1'b0;
            valid <= 1'b0;
            flags <= 3'b000;
            an    <= 4'b1111;
            seg   <= SEG_BLANK;
        end else begin
            if (cnt == CNT_LAST) begin
                cnt <= '0;
                idx <= idx + 2'd1;
            end else begin
                cnt <= cnt + CW'(1);
            end

            if (bus.load) begin
                r_q   <= bus.R;
                zf_q  <= bus.ZF;
                sf_q  <= bus.SF;
                dzf_q <= bus.DZF;
                valid <= 1'b1;
            end

            // Outputs follow idx and the hold registers by one cycle, so an and seg always switch together.
            flags <= {dzf_q, sf_q, zf_q};
            an    <= ~(4'b0001 << idx);
            seg   <= seg_next;
        end
    end
endmodule

// File: tb/tb_alu_display_driver.sv
// Self-checking bench for alu_display_driver with REFRESH_DIV=4: a reference model predicts
// each cycle's an/seg/flags/valid, queues it when stimulus is driven and compares after the edge.
module tb_alu_display_driver;
    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] seg;
    logic [3:0] an;
    logic [2:0] flags;
    logic       valid;

    alu_display_if bus ();

    alu_display_driver #(.REFRESH_DIV(DIV)) dut (
        .clk   (clk),
        .rst   (rst),
        .bus   (bus),
        .seg   (seg),
        .an    (an),
        .flags (flags),
        .valid (valid)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic [2:0] flags;
        logic       valid;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;

    // Reference state: edges since reset release and the values the hold registers should contain.
    int         k = 0;
    logic       m_valid = 1'b0;
    logic [3:0] m_r = 4'd0;
    logic       m_zf = 1'b0;
    logic       m_sf = 1'b0;
    logic       m_dzf = 1'b0;

    task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp_v);
        tests++;
        assert (obs === exp_v)
        else begin
            fails++;
            $error("FAIL %s at k=%0d: observed %b expected %b", tag, k, obs, exp_v);
        end
    endtask

    function automatic logic [6:0] exp_code(input int digit);
        logic [6:0] c;
        c = 7'b1111111;
        if (!m_valid) begin
            c = 7'b0111111;
        end else if (m_dzf) begin
            if (digit == 2) c = 7'b0000110;
            else if (digit == 1 || digit == 0) c = 7'b0101111;
        end else if (digit == 0) begin
            case (m_r[2:0])
                3'd0: c = 7'b1000000;
                3'd1: c = 7'b1111001;
                3'd2: c = 7'b0100100;
                3'd3: c = 7'b0110000;
                3'd4: c = 7'b0011001;
                3'd5: c = 7'b0010010;
                3'd6: c = 7'b0000010;
                3'd7: c = 7'b1111000;
                default: c = 7'b1111111;
            endcase
        end else if (digit == 1 && m_r[3] && m_r[2:0] != 3'd0) begin
            c = 7'b0111111;
        end
        return c;
    endfunction

    task automatic step(input logic rst_i, input logic ld, input logic [3:0] r_i,
                        input logic zf_i, input logic sf_i, input logic dzf_i);
        exp_t e;
        int   digit;
        rst      = rst_i;
        bus.load = ld;
        bus.R    = r_i;
        bus.ZF   = zf_i;
        bus.SF   = sf_i;
        bus.DZF  = dzf_i;
        if (rst_i) begin
            e       = '{an: 4'b1111, seg: 7'b1111111, flags: 3'b000, valid: 1'b0};
            m_valid = 1'b0;
            m_r     = 4'd0;
            m_zf    = 1'b0;
            m_sf    = 1'b0;
            m_dzf   = 1'b0;
            k       = 0;
        end else begin
            digit   = (k / DIV) % 4;
            e.an    = ~(4'b0001 << digit);
            e.seg   = exp_code(digit);
            e.flags = {m_dzf, m_sf, m_zf};
            if (ld) begin
                m_valid = 1'b1;
                m_r     = r_i;
                m_zf    = zf_i;
                m_sf    = sf_i;
                m_dzf   = dzf_i;
            end
            e.valid = m_valid;
            k++;
        end
        q.push_back(e);
        @(posedge clk);
        #1;
        e = q.pop_front();
        check("an",    {3'b000, an},    {3'b000, e.an});
        check("seg",   seg,             e.seg);
        check("flags", {4'b0000, flags}, {4'b0000, e.flags});
        check("valid", {6'b000000, valid}, {6'b000000, e.valid});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic load(input logic [3:0] r_i, input logic zf_i, input logic sf_i, input logic dzf_i);
        step(1'b0, 1'b1, r_i, zf_i, sf_i, dzf_i);
    endtask

    initial begin
        bus.load = 1'b0;
        bus.R    = 4'd0;
        bus.ZF   = 1'b0;
        bus.SF   = 1'b0;
        bus.DZF  = 1'b0;

        // Reset held for three cycles, then one full frame of dashes.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        idle(4 * DIV + 1);

        // Negative three, loaded mid-dwell.
        idle(1);
        load(4'b1011, 1'b0, 1'b1, 1'b0);
        idle(4 * DIV + 2);

        // Negative zero displays as plain 0 with a blank sign digit.
        load(4'b1000, 1'b1, 1'b0, 1'b0);
        idle(4 * DIV + 1);

        // Divide-by-zero, then a normal result restores the number.
        load(4'b0101, 1'b0, 1'b0, 1'b1);
        idle(4 * DIV + 1);
        load(4'b0111, 1'b0, 1'b0, 1'b0);
        idle(4 * DIV);

        // Load on the same edge that advances idx.
        while ((k % DIV) != DIV - 1) idle(1);
        load(4'b1110, 1'b0, 1'b1, 1'b0);
        idle(4 * DIV);

        // Reset with a simultaneous load while digit 2 is selected.
        while (((k / DIV) % 4) != 2) idle(1);
        step(1'b1, 1'b1, 4'b0011, 1'b0, 1'b0, 1'b1);
        idle(4 * DIV + 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
